// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared constants and FSM state type for the dual-issue
//                instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0000;
    localparam int          FETCH_WIDTH = 2;
    localparam int          INST_BYTES  = 4;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_redirect_arb.sv
`default_nettype none
// ============================================================================
//  Module      : if_redirect_arb
//  Description : Redirect arbitration for the fetch stage. Picks between a
//                live execute redirect, an execute redirect latched while the
//                pipeline was hung, and a decode redirect (lowest priority).
//  Ports       : CLK, RST            clock / synchronous active-high reset
//                hang_i              pipeline freeze; latches EX redirects
//                boot_i              fetch FSM in BOOT (decode redirects ignored)
//                id_set_i, id_pc_i   decode redirect request / target
//                ex_set_i, ex_pc_i   execute redirect request / target
//                redirect_take_o     a redirect is applied this cycle
//                redirect_target_o   raw (unmasked) redirect target
//                misalign_o          applied target is not word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module if_redirect_arb (
    input  logic        CLK,
    input  logic        RST,
    input  logic        hang_i,
    input  logic        boot_i,
    input  logic        id_set_i,
    input  logic [31:0] id_pc_i,
    input  logic        ex_set_i,
    input  logic [31:0] ex_pc_i,
    output logic        redirect_take_o,
    output logic [31:0] redirect_target_o,
    output logic        misalign_o
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic        w_ex_take;
    logic        w_id_take;

    // A latched execute redirect is as binding as a live one; a live one
    // still wins the target selection because it is the newer decision.
    assign w_ex_take = !hang_i && (ex_set_i || pend_valid_q);
    assign w_id_take = !hang_i && !boot_i && id_set_i && !w_ex_take;

    always_comb begin
        redirect_take_o   = w_ex_take || w_id_take;
        redirect_target_o = id_pc_i;
        if (ex_set_i) begin
            redirect_target_o = ex_pc_i;
        end else if (pend_valid_q) begin
            redirect_target_o = pend_pc_q;
        end
        misalign_o = redirect_take_o && (redirect_target_o[1:0] != 2'b00);
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (hang_i && ex_set_i) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = ex_pc_i;
        end else if (w_ex_take) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule : if_redirect_arb
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Dual-issue instruction fetch. Owns the fetch PC, reads two
//                consecutive ROM words per cycle and presents them (with their
//                fall-through PCs) to decode one cycle later. Applies execute
//                and decode redirects, inserting a single bubble per redirect.
//  Ports       : CLK, RST                 clock / sync active-high reset
//                pipeline_hang            hold PC and all outputs
//                ID_set_PC, ID_PC         decode re-fetch request / target
//                EX_set_PC, EX_PC         execute redirect (has priority)
//                IAddr1, IAddr2           ROM word addresses (combinational)
//                IData1, IData2           ROM read data
//                inst_1, inst_2           instruction pair (0 = bubble)
//                PC1, PC2                 pc+4 / pc+8 of the pair
//                fetch_valid              pair holds real instructions
//                misalign_err             sticky misaligned-redirect flag
//  Revision    : 1.0 - initial release
// ============================================================================
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               pipeline_hang,
    input  logic               ID_set_PC,
    input  logic [31:0]        ID_PC,
    input  logic               EX_set_PC,
    input  logic [31:0]        EX_PC,
    output logic [IMEM_AW-1:0] IAddr1,
    output logic [IMEM_AW-1:0] IAddr2,
    input  logic [31:0]        IData1,
    input  logic [31:0]        IData2,
    output logic [31:0]        inst_1,
    output logic [31:0]        inst_2,
    output logic [31:0]        PC1,
    output logic [31:0]        PC2,
    output logic               fetch_valid,
    output logic               misalign_err
);

    localparam logic [31:0] c_STEP = 32'(FETCH_WIDTH * INST_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q,    pc_d;
    logic [31:0]  inst1_q, inst1_d;
    logic [31:0]  inst2_q, inst2_d;
    logic [31:0]  pc1_q,   pc1_d;
    logic [31:0]  pc2_q,   pc2_d;
    logic         valid_q, valid_d;
    logic         mis_q,   mis_d;

    logic         w_take;
    logic [31:0]  w_target;
    logic         w_misalign;

    if_redirect_arb u_arb (
        .CLK               (CLK),
        .RST               (RST),
        .hang_i            (pipeline_hang),
        .boot_i            (state_q == BOOT),
        .id_set_i          (ID_set_PC),
        .id_pc_i           (ID_PC),
        .ex_set_i          (EX_set_PC),
        .ex_pc_i           (EX_PC),
        .redirect_take_o   (w_take),
        .redirect_target_o (w_target),
        .misalign_o        (w_misalign)
    );

    // Second address is derived in the ROM index space so that it wraps
    // modulo 2^IMEM_AW exactly like (pc_q+4)[IMEM_AW+1:2].
    assign IAddr1 = pc_q[IMEM_AW+1:2];
    assign IAddr2 = pc_q[IMEM_AW+1:2] + {{(IMEM_AW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst1_d = inst1_q;
        inst2_d = inst2_q;
        pc1_d   = pc1_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        mis_d   = mis_q;

        if (!pipeline_hang) begin
            state_d = RUN;
            if (w_take || (state_q == BOOT)) begin
                inst1_d = NOP_INST;
                inst2_d = NOP_INST;
                pc1_d   = 32'h0;
                pc2_d   = 32'h0;
                valid_d = 1'b0;
                if (w_take) begin
                    pc_d = w_target & ~32'd3;
                end
            end else begin
                inst1_d = IData1;
                inst2_d = IData2;
                pc1_d   = pc_q + 32'(INST_BYTES);
                pc2_d   = pc_q + c_STEP;
                valid_d = 1'b1;
                pc_d    = pc_q + c_STEP;
            end
            if (w_misalign) begin
                mis_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst1_q <= NOP_INST;
            inst2_q <= NOP_INST;
            pc1_q   <= 32'h0;
            pc2_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst1_q <= inst1_d;
            inst2_q <= inst2_d;
            pc1_q   <= pc1_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign inst_1       = inst1_q;
    assign inst_2       = inst2_q;
    assign PC1          = pc1_q;
    assign PC2          = pc2_q;
    assign fetch_valid  = valid_q;
    assign misalign_err = mis_q;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. Directed vector table,
//                hand-written corner sequences (ROM wrap, reset during hang,
//                decode redirect during BOOT) and random stimulus against a
//                behavioural fetch model. ROM contents: word n holds n+100.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pipeline_hang;
    logic        ID_set_PC;
    logic [31:0] ID_PC;
    logic        EX_set_PC;
    logic [31:0] EX_PC;

    logic [9:0]  IAddr1, IAddr2;
    logic [31:0] IData1, IData2, inst_1, inst_2, PC1, PC2;
    logic        fetch_valid, misalign_err;

    logic [3:0]  s_IAddr1, s_IAddr2;
    logic [31:0] s_IData1, s_IData2, s_inst_1, s_inst_2, s_PC1, s_PC2;
    logic        s_fetch_valid, s_misalign_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    assign IData1   = {22'h0, IAddr1} + 32'd100;
    assign IData2   = {22'h0, IAddr2} + 32'd100;
    assign s_IData1 = {28'h0, s_IAddr1} + 32'd100;
    assign s_IData2 = {28'h0, s_IAddr2} + 32'd100;

    if_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) u_dut (
        .CLK(CLK), .RST(RST), .pipeline_hang(pipeline_hang),
        .ID_set_PC(ID_set_PC), .ID_PC(ID_PC),
        .EX_set_PC(EX_set_PC), .EX_PC(EX_PC),
        .IAddr1(IAddr1), .IAddr2(IAddr2), .IData1(IData1), .IData2(IData2),
        .inst_1(inst_1), .inst_2(inst_2), .PC1(PC1), .PC2(PC2),
        .fetch_valid(fetch_valid), .misalign_err(misalign_err)
    );

    if_stage #(.RESET_PC(32'h0), .IMEM_AW(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .pipeline_hang(pipeline_hang),
        .ID_set_PC(ID_set_PC), .ID_PC(ID_PC),
        .EX_set_PC(EX_set_PC), .EX_PC(EX_PC),
        .IAddr1(s_IAddr1), .IAddr2(s_IAddr2), .IData1(s_IData1), .IData2(s_IData2),
        .inst_1(s_inst_1), .inst_2(s_inst_2), .PC1(s_PC1), .PC2(s_PC2),
        .fetch_valid(s_fetch_valid), .misalign_err(s_misalign_err)
    );

    typedef struct {
        logic        hang;
        logic        ids;
        logic [31:0] idpc;
        logic        exs;
        logic [31:0] expc;
        logic [31:0] i1, i2, p1, p2;
        logic        v, mis;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic hang, logic ids, logic [31:0] idpc,
                                logic exs, logic [31:0] expc,
                                logic [31:0] i1, logic [31:0] i2,
                                logic [31:0] p1, logic [31:0] p2,
                                logic v, logic mis, logic [31:0] pc);
        vec_t r;
        r.hang = hang; r.ids = ids; r.idpc = idpc; r.exs = exs; r.expc = expc;
        r.i1 = i1; r.i2 = i2; r.p1 = p1; r.p2 = p2; r.v = v; r.mis = mis; r.pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic h, input logic ids, input logic [31:0] idpc,
                         input logic exs, input logic [31:0] expc);
        pipeline_hang = h; ID_set_PC = ids; ID_PC = idpc; EX_set_PC = exs; EX_PC = expc;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [159:0] outs(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                          logic [31:0] d, logic v, logic m);
        return {a, b, c, d, 30'h0, v, m};
    endfunction

    // Behavioural model: fetch state expressed in architectural terms.
    logic        m_boot, m_pend;
    logic [31:0] m_pc, m_pend_pc, m_i1, m_i2, m_p1, m_p2;
    logic        m_v, m_mis;

    function automatic logic [31:0] rom10(logic [31:0] byte_addr);
        return ((byte_addr >> 2) % 1024) + 100;
    endfunction

    task automatic model_reset();
        m_boot = 1; m_pend = 0; m_pend_pc = 0; m_pc = 0;
        m_i1 = 0; m_i2 = 0; m_p1 = 0; m_p2 = 0; m_v = 0; m_mis = 0;
    endtask

    task automatic model_step(input logic h, input logic ids, input logic [31:0] idpc,
                              input logic exs, input logic [31:0] expc);
        logic        have;
        logic [31:0] tgt;
        if (h) begin
            if (exs) begin m_pend = 1; m_pend_pc = expc; end
            return;
        end
        have = 1; tgt = 0;
        if (exs)                tgt = expc;
        else if (m_pend)        tgt = m_pend_pc;
        else if (ids && !m_boot) tgt = idpc;
        else                    have = 0;
        m_pend = 0;
        if (have) begin
            m_pc = {tgt[31:2], 2'b00};
            m_i1 = 0; m_i2 = 0; m_p1 = 0; m_p2 = 0; m_v = 0;
            if (tgt[1:0] != 0) m_mis = 1;
        end else if (m_boot) begin
            m_i1 = 0; m_i2 = 0; m_p1 = 0; m_p2 = 0; m_v = 0;
        end else begin
            m_i1 = rom10(m_pc); m_i2 = rom10(m_pc + 4);
            m_p1 = m_pc + 4;    m_p2 = m_pc + 8; m_v = 1;
            m_pc = m_pc + 8;
        end
        m_boot = 0;
    endtask

    initial begin
        // hang ids idpc  exs expc       i1   i2   p1     p2     v  mis pc
        tbl[0]  = mk(0,0,0,     0,0,          0,   0,   0,     0,     0, 0, 32'h00);
        tbl[1]  = mk(0,0,0,     0,0,          100, 101, 4,     8,     1, 0, 32'h08);
        tbl[2]  = mk(0,0,0,     0,0,          102, 103, 12,    16,    1, 0, 32'h10);
        tbl[3]  = mk(0,1,32'h14,0,0,          0,   0,   0,     0,     0, 0, 32'h14);
        tbl[4]  = mk(0,0,0,     0,0,          105, 106, 32'h18,32'h1C,1, 0, 32'h1C);
        tbl[5]  = mk(0,1,32'h08,1,32'h40,     0,   0,   0,     0,     0, 0, 32'h40);
        tbl[6]  = mk(0,0,0,     0,0,          116, 117, 32'h44,32'h48,1, 0, 32'h48);
        tbl[7]  = mk(1,0,0,     0,0,          116, 117, 32'h44,32'h48,1, 0, 32'h48);
        tbl[8]  = mk(1,0,0,     1,32'h80,     116, 117, 32'h44,32'h48,1, 0, 32'h48);
        tbl[9]  = mk(1,0,0,     0,0,          116, 117, 32'h44,32'h48,1, 0, 32'h48);
        tbl[10] = mk(0,0,0,     0,0,          0,   0,   0,     0,     0, 0, 32'h80);
        tbl[11] = mk(0,0,0,     0,0,          132, 133, 32'h84,32'h88,1, 0, 32'h88);
        tbl[12] = mk(0,0,0,     1,32'h22,     0,   0,   0,     0,     0, 1, 32'h20);
        tbl[13] = mk(0,0,0,     0,0,          108, 109, 32'h24,32'h28,1, 1, 32'h28);
        tbl[14] = mk(1,1,32'h0, 0,0,          108, 109, 32'h24,32'h28,1, 1, 32'h28);
        tbl[15] = mk(0,0,0,     0,0,          110, 111, 32'h2C,32'h30,1, 1, 32'h30);

        RST = 1; drive(0, 0, 0, 0, 0);
        step();
        chk("reset_outputs", outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err),
            outs(0, 0, 0, 0, 0, 0));
        chk("reset_iaddr", {150'h0, IAddr1}, {150'h0, 10'd0});
        RST = 0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].hang, tbl[i].ids, tbl[i].idpc, tbl[i].exs, tbl[i].expc);
            step();
            chk($sformatf("vec%0d_outputs", i),
                outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err),
                outs(tbl[i].i1, tbl[i].i2, tbl[i].p1, tbl[i].p2, tbl[i].v, tbl[i].mis));
            chk($sformatf("vec%0d_iaddr", i), {140'h0, IAddr1, IAddr2},
                {140'h0, tbl[i].pc[11:2], tbl[i].p2[11:2] == 0 ? (tbl[i].pc[11:2] + 10'd1) : (tbl[i].pc[11:2] + 10'd1)});
        end

        // ROM index wrap on the 16-word instance.
        drive(0, 0, 0, 1, 32'h38); step();
        chk("wrap_iaddr_38", {152'h0, s_IAddr1, s_IAddr2}, {152'h0, 4'd14, 4'd15});
        drive(0, 0, 0, 0, 0); step();
        chk("wrap_iaddr_40", {152'h0, s_IAddr1, s_IAddr2}, {152'h0, 4'd0, 4'd1});
        chk("wrap_fetch_38", outs(s_inst_1, s_inst_2, s_PC1, s_PC2, s_fetch_valid, 1'b0),
            outs(114, 115, 32'h3C, 32'h40, 1, 0));
        step();
        chk("wrap_fetch_40", outs(s_inst_1, s_inst_2, s_PC1, s_PC2, s_fetch_valid, 1'b0),
            outs(100, 101, 32'h44, 32'h48, 1, 0));
        chk("wrap_iaddr_48", {152'h0, s_IAddr1, s_IAddr2}, {152'h0, 4'd2, 4'd3});
        drive(0, 0, 0, 1, 32'h3C); step();
        chk("wrap_iaddr_3c", {152'h0, s_IAddr1, s_IAddr2}, {152'h0, 4'd15, 4'd0});
        drive(0, 0, 0, 0, 0); step();
        chk("wrap_fetch_3c", outs(s_inst_1, s_inst_2, s_PC1, s_PC2, s_fetch_valid, 1'b0),
            outs(115, 100, 32'h40, 32'h44, 1, 0));

        // Reset during a hang discards the pending redirect; BOOT ignores decode.
        drive(1, 0, 0, 1, 32'h100); step();
        RST = 1; drive(1, 0, 0, 0, 0); step();
        chk("midreset_outputs", outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err),
            outs(0, 0, 0, 0, 0, 0));
        RST = 0; drive(0, 1, 32'h60, 0, 0); step();
        chk("boot_bubble", outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err),
            outs(0, 0, 0, 0, 0, 0));
        chk("boot_ignores_id", {150'h0, IAddr1}, {150'h0, 10'd0});
        drive(0, 0, 0, 0, 0); step();
        chk("post_boot_fetch", outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err),
            outs(100, 101, 4, 8, 1, 0));

        // Random stimulus against the behavioural model.
        RST = 1; drive(0, 0, 0, 0, 0); step(); RST = 0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic        h, ids, exs;
            logic [31:0] idpc, expc;
            h    = ($urandom_range(0, 3) == 0);
            ids  = ($urandom_range(0, 4) == 0);
            exs  = ($urandom_range(0, 6) == 0);
            idpc = $urandom;
            expc = $urandom;
            if ($urandom_range(0, 7) != 0) idpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) expc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) expc = 32'hFFFF_FFF0;
            drive(h, ids, idpc, exs, expc);
            step();
            model_step(h, ids, idpc, exs, expc);
            chk($sformatf("rand%0d", c),
                {outs(inst_1, inst_2, PC1, PC2, fetch_valid, misalign_err) ^ {128'h0, 22'h0, IAddr1}},
                {outs(m_i1, m_i2, m_p1, m_p2, m_v, m_mis) ^ {128'h0, 22'h0, m_pc[11:2]}});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Dual-issue instruction fetch stage. Supplies the decode stage with an instruction pair (inst_1, inst_2) and the matching PC1/PC2 every cycle.
- Owns the architectural fetch PC. Reads two consecutive words from the instruction memory.
- Obeys redirects from decode (partial issue / re-fetch) and from execute (beq/j resolution). Execute redirects take priority.
- Sits between the instruction ROM and ID_stage.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_AW, 10, instruction ROM word-address width; addresses wrap modulo 2^IMEM_AW words.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- pipeline_hang  in  1  freeze fetch: hold PC and all outputs.
- ID_set_PC  in  1  decode requests re-fetch from ID_PC.
- ID_PC  in  32  decode redirect target (byte address).
- EX_set_PC  in  1  execute branch/jump redirect; overrides ID_set_PC.
- EX_PC  in  32  execute redirect target.
- IAddr1  out  IMEM_AW  ROM word address of first instruction = pc_q[IMEM_AW+1:2].
- IAddr2  out  IMEM_AW  ROM word address of second instruction = (pc_q+4)[IMEM_AW+1:2].
- IData1  in  32  ROM data for IAddr1 (combinational read).
- IData2  in  32  ROM data for IAddr2 (combinational read).
- inst_1  out  32  first instruction to decode (0 = bubble).
- inst_2  out  32  second instruction to decode.
- PC1  out  32  address following inst_1 (pc+4).
- PC2  out  32  address following inst_2 (pc+8).
- fetch_valid  out  1  1 when inst_1/inst_2 are real fetched instructions, not a bubble.
- misalign_err  out  1  sticky; set when any redirect target has [1:0]!=0.

Behaviour:
- Reset (RST=1 at posedge): pc_q<=RESET_PC; inst_1, inst_2, PC1, PC2 <=0; fetch_valid<=0; misalign_err<=0; pend_valid<=0; state<=BOOT.
- RST overrides everything, including hang and redirects. Mid-operation reset discards any pending redirect.
- FSM:
  - BOOT: one cycle. Outputs stay bubble; pc_q unchanged. Then goes to RUN. This cycle ignores ID_set_PC; EX_set_PC is handled as in RUN.
  - RUN: normal operation.
- IAddr1/IAddr2 are combinational from pc_q. Data latency = 1 cycle: the ROM words at pc_q appear on inst_1/inst_2 at the next posedge.
- RUN, pipeline_hang=0, evaluated in priority order per posedge:
  1. Redirect from execute (EX_set_PC=1 or pend_valid=1):
     - target = EX_PC if EX_set_PC=1, else pend_pc.
     - pc_q<=target & ~3.
     - Outputs <= bubble: inst_1=inst_2=0, PC1=PC2=0, fetch_valid=0.
     - pend_valid<=0.
  2. Redirect from decode (ID_set_PC=1): pc_q<=ID_PC & ~3; outputs <= bubble.
  3. Otherwise:
     - inst_1<=IData1, inst_2<=IData2.
     - PC1<=pc_q+4, PC2<=pc_q+8.
     - fetch_valid<=1, pc_q<=pc_q+8.
- pipeline_hang=1:
  - pc_q and all outputs hold.
  - EX_set_PC=1 during hang latches pend_pc<=EX_PC and pend_valid<=1; a later EX_set_PC overwrites it. The pending redirect is applied on the first non-hang cycle with execute priority.
  - ID_set_PC during hang is dropped; decode reasserts it.
- Simultaneous EX_set_PC and ID_set_PC: EX wins; ID_PC is ignored.
- misalign_err is set on an applied redirect whose target[1:0]!=0. It clears only on RST.
- Arithmetic: pc_q is 32-bit and wraps at 2^32. ROM indexing wraps modulo 2^IMEM_AW; no fault is raised on wrap.
- Back-to-back redirects: each applied redirect produces exactly one bubble output cycle. The fetch from the new target appears the following cycle.

Decomposition:
- Shared package/macro file:
  - NOP_INST = 32'h0.
  - FETCH_WIDTH = 2.
  - INST_BYTES = 4.
  - FSM state encodings BOOT=1'b0, RUN=1'b1.
- One natural sub-module: if_redirect_arb. Combinational priority of pending/EX/ID redirects, plus the pending latch (pend_pc, pend_valid). Returns redirect_take, redirect_target, misalign.
- The instruction ROM stays external.

Test Plan:
- Reset release, RESET_PC=0, ROM[n]=n+100 -> cycle 1 after reset: bubble (BOOT). Cycle 2: inst_1=100, inst_2=101, PC1=4, PC2=8, fetch_valid=1. Cycle 3: inst_1=102, inst_2=103, PC1=12, PC2=16.
- In RUN at pc_q=0x10, pulse ID_set_PC=1 with ID_PC=0x14 -> next cycle: bubble (inst 0, fetch_valid=0). Following cycle: inst_1=ROM[5], inst_2=ROM[6], PC1=0x18, PC2=0x1C.
- EX_set_PC=1 with EX_PC=0x40 and ID_set_PC=1 with ID_PC=0x8, same cycle -> bubble, then inst_1=ROM[16], PC1=0x44; ID target never fetched.
- pipeline_hang=1 for 3 cycles, EX_set_PC pulsed on hang cycle 2 with EX_PC=0x80 -> outputs frozen throughout the hang. First cycle after hang: bubble. Next cycle: inst_1=ROM[32], PC1=0x84.
- EX_PC=0x22 -> misalign_err=1; fetch from 0x20 (inst_1=ROM[8]). misalign_err stays 1 until RST.
- IMEM_AW=4, run from pc 0x38 -> IAddr1=14, IAddr2=15. Then pc 0x40 gives IAddr1=0, IAddr2=1 (wrap); pc_q continues at 0x40/0x48.
